// File: rtl/rx_byte_to_word.sv
// Packs the receiver's decoded byte stream little-endian into 64-bit words and
// queues them in a first-word-fall-through FIFO. It also reports one status
// strobe per packet with the FCS result, the byte count and the overflow and
// abort flags.
module rx_byte_to_word #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int WORD_WIDTH      = 64
) (
    input  logic                     s00_axi_aclk,
    input  logic                     s00_axi_aresetn,
    input  logic                     pkt_header_valid_strobe,
    input  logic                     pkt_header_valid,
    input  logic [15:0]              pkt_len,
    input  logic                     byte_out_strobe,
    input  logic [7:0]               byte_out,
    input  logic                     fcs_out_strobe,
    input  logic                     fcs_ok,
    output logic [WORD_WIDTH-1:0]    m_word,
    output logic [3:0]               m_word_keep,
    output logic                     m_word_last,
    output logic                     m_word_valid,
    input  logic                     m_word_ready,
    output logic                     pkt_done_strobe,
    output logic                     pkt_fcs_ok,
    output logic [15:0]              pkt_byte_cnt,
    output logic                     pkt_overflow,
    output logic                     pkt_aborted,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int          PTR_W   = FIFO_DEPTH_LOG2;
    localparam int          LEVEL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int          ENTRY_W = WORD_WIDTH + 4 + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_FCS,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic sig_valid;
    assign sig_valid = pkt_header_valid_strobe & pkt_header_valid;

    // Packet datapath registers
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    // Word staged for the FIFO write on the following cycle
    logic                  stg_en_q, stg_en_d;
    logic [WORD_WIDTH-1:0] stg_word_q, stg_word_d;
    logic [3:0]            stg_keep_q, stg_keep_d;
    logic                  stg_last_q, stg_last_d;
    // Status outputs
    logic                  done_q, done_d;
    logic                  done_fcs_q, done_fcs_d;
    logic [15:0]           done_cnt_q, done_cnt_d;
    logic                  done_ovf_q, done_ovf_d;
    logic                  done_abort_q, done_abort_d;

    logic                  finish;
    logic                  aborting;
    logic [WORD_WIDTH-1:0] buf_new;

    // FIFO
    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    count_q, count_d;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  fifo_drop;

    // State register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort header is remembered in pend_q so DONE can
    // launch the new packet directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sig_valid) begin
                    state_d = (pkt_len == '0) ? WAIT_FCS : COLLECT;
                end
            end
            COLLECT: begin
                if (sig_valid || fcs_out_strobe) begin
                    state_d = DONE;
                end else if (byte_out_strobe && ((cnt_q + 16'd1) == len_q)) begin
                    state_d = WAIT_FCS;
                end
            end
            WAIT_FCS: begin
                if (sig_valid || fcs_out_strobe) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sig_valid) begin
                    state_d = (pkt_len == '0) ? WAIT_FCS : COLLECT;
                end else if (pend_q) begin
                    state_d = (len_q == '0) ? WAIT_FCS : COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: lane filling, word staging and status capture
    always_comb begin
        len_d        = len_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q | fifo_drop;
        stg_en_d     = 1'b0;
        stg_word_d   = '0;
        stg_keep_d   = '0;
        stg_last_d   = 1'b0;
        done_d       = 1'b0;
        done_fcs_d   = done_fcs_q;
        done_cnt_d   = done_cnt_q;
        done_ovf_d   = done_ovf_q;
        done_abort_d = done_abort_q;
        finish       = 1'b0;
        aborting     = 1'b0;
        buf_new      = buf_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (cnt_q[2:0] == 3'(i)) begin
                buf_new[i*8 +: 8] = byte_out;
            end
        end

        case (state_q)
            IDLE: begin
                if (sig_valid) begin
                    len_d  = pkt_len;
                    cnt_d  = '0;
                    buf_d  = '0;
                    ovf_d  = 1'b0;
                    pend_d = 1'b0;
                end
            end
            COLLECT: begin
                if (sig_valid || fcs_out_strobe) begin
                    finish   = 1'b1;
                    aborting = sig_valid;
                    if (cnt_q[2:0] != 3'd0) begin
                        stg_en_d   = 1'b1;
                        stg_word_d = buf_q;
                        stg_keep_d = {1'b0, cnt_q[2:0]};
                        stg_last_d = 1'b1;
                    end
                    buf_d = '0;
                end else if (byte_out_strobe) begin
                    cnt_d = cnt_q + 16'd1;
                    buf_d = buf_new;
                    if ((cnt_q[2:0] == 3'd7) || (cnt_d == len_q)) begin
                        stg_en_d   = 1'b1;
                        stg_word_d = buf_new;
                        stg_keep_d = {1'b0, cnt_q[2:0]} + 4'd1;
                        stg_last_d = (cnt_d == len_q);
                        buf_d      = '0;
                    end
                end
            end
            WAIT_FCS: begin
                if (sig_valid || fcs_out_strobe) begin
                    finish   = 1'b1;
                    aborting = sig_valid;
                end
            end
            DONE: begin
                cnt_d  = '0;
                buf_d  = '0;
                ovf_d  = 1'b0;
                pend_d = 1'b0;
                if (sig_valid) begin
                    len_d = pkt_len;
                end
            end
            default: ;
        endcase

        if (finish) begin
            done_d       = 1'b1;
            done_cnt_d   = cnt_q;
            done_ovf_d   = ovf_q | fifo_drop;
            done_abort_d = aborting;
            done_fcs_d   = aborting ? 1'b0 : fcs_ok;
            if (aborting) begin
                len_d  = pkt_len;
                pend_d = 1'b1;
            end
        end
    end

    // Datapath and status registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            len_q        <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            pend_q       <= 1'b0;
            ovf_q        <= 1'b0;
            stg_en_q     <= 1'b0;
            stg_word_q   <= '0;
            stg_keep_q   <= '0;
            stg_last_q   <= 1'b0;
            done_q       <= 1'b0;
            done_fcs_q   <= 1'b0;
            done_cnt_q   <= '0;
            done_ovf_q   <= 1'b0;
            done_abort_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
            stg_en_q     <= stg_en_d;
            stg_word_q   <= stg_word_d;
            stg_keep_q   <= stg_keep_d;
            stg_last_q   <= stg_last_d;
            done_q       <= done_d;
            done_fcs_q   <= done_fcs_d;
            done_cnt_q   <= done_cnt_d;
            done_ovf_q   <= done_ovf_d;
            done_abort_q <= done_abort_d;
        end
    end

    // FIFO control: a push into a full FIFO is taken only if a pop frees a slot
    always_comb begin
        fifo_full = (count_q == LEVEL_W'(DEPTH));
        fifo_pop  = m_word_valid & m_word_ready;
        fifo_push = stg_en_q & (~fifo_full | fifo_pop);
        fifo_drop = stg_en_q & fifo_full & ~fifo_pop;
        wr_ptr_d  = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + LEVEL_W'(1);
            2'b01:   count_d = count_q - LEVEL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage
    always_ff @(posedge s00_axi_aclk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= {stg_word_q, stg_keep_q, stg_last_q};
        end
    end

    // Head entry is masked so the outputs read zero whenever the FIFO is empty
    assign m_word_valid = (count_q != '0);
    assign {m_word, m_word_keep, m_word_last} = m_word_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level      = count_q;
    assign pkt_done_strobe = done_q;
    assign pkt_fcs_ok      = done_fcs_q;
    assign pkt_byte_cnt    = done_cnt_q;
    assign pkt_overflow    = done_ovf_q;
    assign pkt_aborted     = done_abort_q;

endmodule

// File: tb/tb_rx_byte_to_word.sv
// Randomized self-checking bench for rx_byte_to_word with a packet-level model.
module tb_rx_byte_to_word;

    localparam int LOG2  = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_header_valid_strobe = 1'b0;
    logic        pkt_header_valid = 1'b0;
    logic [15:0] pkt_len = '0;
    logic        byte_out_strobe = 1'b0;
    logic [7:0]  byte_out = '0;
    logic        fcs_out_strobe = 1'b0;
    logic        fcs_ok = 1'b0;
    logic [63:0] m_word;
    logic [3:0]  m_word_keep;
    logic        m_word_last;
    logic        m_word_valid;
    logic        m_word_ready = 1'b1;
    logic        pkt_done_strobe;
    logic        pkt_fcs_ok;
    logic [15:0] pkt_byte_cnt;
    logic        pkt_overflow;
    logic        pkt_aborted;
    logic [LOG2:0] fifo_level;

    always #5 clk = ~clk;

    rx_byte_to_word #(.FIFO_DEPTH_LOG2(LOG2), .WORD_WIDTH(64)) dut (
        .s00_axi_aclk           (clk),
        .s00_axi_aresetn        (rst_n),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid       (pkt_header_valid),
        .pkt_len                (pkt_len),
        .byte_out_strobe        (byte_out_strobe),
        .byte_out               (byte_out),
        .fcs_out_strobe         (fcs_out_strobe),
        .fcs_ok                 (fcs_ok),
        .m_word                 (m_word),
        .m_word_keep            (m_word_keep),
        .m_word_last            (m_word_last),
        .m_word_valid           (m_word_valid),
        .m_word_ready           (m_word_ready),
        .pkt_done_strobe        (pkt_done_strobe),
        .pkt_fcs_ok             (pkt_fcs_ok),
        .pkt_byte_cnt           (pkt_byte_cnt),
        .pkt_overflow           (pkt_overflow),
        .pkt_aborted            (pkt_aborted),
        .fifo_level             (fifo_level)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct { logic [63:0] w; logic [3:0] keep; logic last; } word_t;
    typedef struct { logic fcs; logic [15:0] cnt; logic ovf; logic abrt; } stat_t;

    word_t exp_w[$];
    stat_t exp_s[$];
    logic [7:0] pb[$];

    bit rand_rdy = 1'b0;
    bit rdy_val  = 1'b1;

    initial forever begin
        @(posedge clk);
        #1;
        m_word_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Monitor: popped words and status strobes against the model queues
    bit    held = 1'b0;
    word_t hw;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && m_word_valid) begin
                chk("stall_word", m_word, hw.w);
                chk("stall_keep", {60'd0, m_word_keep}, {60'd0, hw.keep});
                chk("stall_last", {63'd0, m_word_last}, {63'd0, hw.last});
            end
            if (m_word_valid && m_word_ready) begin
                if (exp_w.size() == 0) begin
                    chk("word_unexpected", {63'd0, m_word_valid}, 64'd0);
                end else begin
                    word_t e;
                    e = exp_w.pop_front();
                    chk("word", m_word, e.w);
                    chk("keep", {60'd0, m_word_keep}, {60'd0, e.keep});
                    chk("last", {63'd0, m_word_last}, {63'd0, e.last});
                end
            end
            held  = m_word_valid && !m_word_ready;
            hw.w    = m_word;
            hw.keep = m_word_keep;
            hw.last = m_word_last;
            if (pkt_done_strobe) begin
                if (exp_s.size() == 0) begin
                    chk("done_unexpected", {63'd0, pkt_done_strobe}, 64'd0);
                end else begin
                    stat_t s;
                    s = exp_s.pop_front();
                    chk("pkt_fcs_ok", {63'd0, pkt_fcs_ok}, {63'd0, s.fcs});
                    chk("pkt_byte_cnt", {48'd0, pkt_byte_cnt}, {48'd0, s.cnt});
                    chk("pkt_overflow", {63'd0, pkt_overflow}, {63'd0, s.ovf});
                    chk("pkt_aborted", {63'd0, pkt_aborted}, {63'd0, s.abrt});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic hdr(input logic [15:0] len, input logic ok);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = ok;
        pkt_len                 = len;
        tick();
        pkt_header_valid_strobe = 1'b0;
        pkt_header_valid        = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        byte_out_strobe = 1'b1;
        byte_out        = b;
        tick();
        byte_out_strobe = 1'b0;
    endtask

    task automatic fcs(input logic ok);
        fcs_out_strobe = 1'b1;
        fcs_ok         = ok;
        tick();
        fcs_out_strobe = 1'b0;
    endtask

    task automatic gen(input int n, input bit seq);
        pb.delete();
        for (int i = 0; i < n; i++) pb.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    // Words for the first acc bytes of pb; a trailing partial word always
    // carries last, a full final word only when the packet completed.
    task automatic model_words(input int acc, input bit complete, input int max_words);
        int nch;
        nch = (acc + 7) / 8;
        for (int c = 0; c < nch; c++) begin
            word_t e;
            int nb;
            nb = ((acc - c * 8) >= 8) ? 8 : (acc - c * 8);
            e.w = '0;
            for (int j = 0; j < nb; j++) e.w[j*8 +: 8] = pb[c*8 + j];
            e.keep = 4'(nb);
            e.last = (c == nch - 1) && (complete || nb < 8);
            if (c < max_words) exp_w.push_back(e);
        end
    endtask

    task automatic model_stat(input logic f, input int cnt, input logic ovf, input logic ab);
        stat_t s;
        s.fcs = f; s.cnt = 16'(cnt); s.ovf = ovf; s.abrt = ab;
        exp_s.push_back(s);
    endtask

    task automatic send_pb(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            put_byte(pb[i]);
            if (gaps) gap($urandom_range(0, 1));
        end
    endtask

    task automatic run_normal(input int len, input int extra, input logic f, input bit seq, input bit gaps);
        gen(len + extra, seq);
        model_words(len, 1'b1, 1000);
        model_stat(f, len, 1'b0, 1'b0);
        hdr(16'(len), 1'b1);
        send_pb(len + extra, gaps);
        fcs(f);
    endtask

    task automatic run_short(input int len, input int n, input logic f, input bit gaps);
        gen(n, 1'b0);
        model_words(n, 1'b0, 1000);
        model_stat(f, n, 1'b0, 1'b0);
        hdr(16'(len), 1'b1);
        send_pb(n, gaps);
        fcs(f);
    endtask

    task automatic run_abort(input int len1, input int k, input int len2, input logic f2, input bit gaps);
        gen(k, 1'b0);
        model_words(k, 1'b0, 1000);
        model_stat(1'b0, k, 1'b0, 1'b1);
        hdr(16'(len1), 1'b1);
        send_pb(k, gaps);
        gen(len2, 1'b0);
        model_words(len2, 1'b1, 1000);
        model_stat(f2, len2, 1'b0, 1'b0);
        hdr(16'(len2), 1'b1);
        put_byte(8'hEE);
        send_pb(len2, gaps);
        fcs(f2);
    endtask

    task automatic drain(input string tag);
        int i;
        gap(2);
        i = 0;
        while (fifo_level != 0 && i < 3000) begin
            tick();
            i++;
        end
        gap(2);
        chk({tag, "_level"}, {59'd0, fifo_level}, 64'd0);
        chk({tag, "_words_left"}, 64'(exp_w.size()), 64'd0);
        chk({tag, "_stats_left"}, 64'(exp_s.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, m_word_valid}, 64'd0);
        chk("rst_level", {59'd0, fifo_level}, 64'd0);
        chk("rst_word", m_word, 64'd0);
        chk("rst_done", {63'd0, pkt_done_strobe}, 64'd0);
        chk("rst_cnt", {48'd0, pkt_byte_cnt}, 64'd0);
        rst_n = 1'b1;
        gap(2);

        // 1: 20 sequential bytes, with fill-to-valid latency of the first word
        gen(20, 1'b1);
        model_words(20, 1'b1, 1000);
        model_stat(1'b1, 20, 1'b0, 1'b0);
        hdr(16'd20, 1'b1);
        for (int i = 0; i < 8; i++) put_byte(pb[i]);
        @(negedge clk);
        chk("lat_cycle1", {63'd0, m_word_valid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2", {63'd0, m_word_valid}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 8; i < 20; i++) put_byte(pb[i]);
        fcs(1'b1);
        drain("t1");

        // 2: bytes beyond pkt_len are ignored
        run_normal(8, 2, 1'b1, 1'b1, 1'b0);
        drain("t2");

        // 3: FIFO saturation with ready low, then drain
        rdy_val = 1'b0;
        gap(2);
        gen(200, 1'b0);
        model_words(200, 1'b1, DEPTH);
        model_stat(1'b1, 200, 1'b1, 1'b0);
        hdr(16'd200, 1'b1);
        send_pb(200, 1'b0);
        fcs(1'b1);
        gap(3);
        chk("t3_level_sat", {59'd0, fifo_level}, 64'(DEPTH));
        rdy_val = 1'b1;
        drain("t3");

        // 4: abort after 13 bytes, then a 4-byte packet
        run_abort(100, 13, 4, 1'b1, 1'b0);
        drain("t4");

        // 5: zero-length packet with failing FCS
        run_normal(0, 0, 1'b0, 1'b0, 1'b0);
        drain("t5");

        // 6: random ready during the 20-byte packet
        rand_rdy = 1'b1;
        run_normal(20, 0, 1'b1, 1'b1, 1'b0);
        drain("t6");

        // Randomized packets with ignored IDLE traffic before each one
        for (int p = 0; p < 40; p++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 128);
            put_byte(8'($urandom));
            hdr(16'($urandom), 1'b0);
            fcs(1'b1);
            case (mode)
                0: run_normal($urandom_range(0, 128), $urandom_range(0, 3), 1'($urandom), 1'b0, 1'b1);
                1: run_short(len, $urandom_range(0, len - 1), 1'($urandom), 1'b1);
                default: run_abort(len, $urandom_range(0, len - 1), $urandom_range(0, 128), 1'($urandom), 1'b1);
            endcase
            drain("rnd");
        end

        // Reset mid-packet with words queued
        rand_rdy = 1'b0;
        rdy_val  = 1'b0;
        gap(2);
        hdr(16'd100, 1'b1);
        for (int i = 0; i < 40; i++) put_byte(8'($urandom));
        tick();
        chk("pre_rst_level", {59'd0, fifo_level}, 64'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", {59'd0, fifo_level}, 64'd0);
        chk("mid_rst_valid", {63'd0, m_word_valid}, 64'd0);
        chk("mid_rst_word", m_word, 64'd0);
        gap(2);
        rst_n   = 1'b1;
        rdy_val = 1'b1;
        gap(2);
        run_normal(12, 0, 1'b1, 1'b0, 1'b0);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
